fdiv16_async_retime_core: RTL and testbench



---
 rtl/fdiv_pkg.sv | 7 +
 rtl/fdiv_toggle_stage.sv | 28 ++
 rtl/fdiv16_async_retime_core.sv | 61 ++++++
 tb/tb_fdiv16_async_retime_core.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared constants for the ripple clock divider family.
package fdiv_pkg;

    localparam int unsigned STAGES_DEFAULT = 4;
    localparam real         F_IN_NOM       = 2.0e9;

endpackage : fdiv_pkg

// File: rtl/fdiv_toggle_stage.sv
// One ripple toggle flop. Its clock is the input clock while in reset and the
// inverted previous stage otherwise, so every stage still sees edges to clear on.
module fdiv_toggle_stage (
    input  logic clk_i,
    input  logic rst_q_i,
    input  logic q_prev_i,
    output logic q_o
);

    logic stage_clk_c;
    logic q_q;
    logic q_d;

    // Release is glitch-free: rst_q rises with clk_i high while ~q_prev is also high.
    assign stage_clk_c = rst_q_i ? ~q_prev_i : clk_i;
    assign q_d         = ~q_q;

    always_ff @(posedge stage_clk_c) begin
        if (!rst_q_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : fdiv_toggle_stage

// File: rtl/fdiv16_async_retime_core.sv
// Divide-by-2^STAGES ripple clock divider with a falling-edge retimed copy of
// its output, so downstream logic sees single-flop skew instead of ripple skew.
module fdiv16_async_retime_core
    import fdiv_pkg::*;
#(
    parameter int unsigned STAGES = STAGES_DEFAULT
) (
    input  logic in,
    input  logic rstn,
    output logic out_async,
    output logic out_retimed
);

    logic              rst_q;
    logic              q0_q;
    logic              q0_d;
    logic              retime_q;
    logic              retime_d;
    logic [STAGES-1:0] q;

    always_ff @(posedge in) begin
        rst_q <= rstn;
    end

    // Stage 0 runs directly on the input clock.
    assign q0_d = ~q0_q;

    always_ff @(posedge in) begin
        if (!rst_q) begin
            q0_q <= 1'b0;
        end else begin
            q0_q <= q0_d;
        end
    end

    assign q[0] = q0_q;

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        fdiv_toggle_stage u_stage (
            .clk_i    (in),
            .rst_q_i  (rst_q),
            .q_prev_i (q[k-1]),
            .q_o      (q[k])
        );
    end

    // Falling-edge capture leaves half an input period for the ripple to settle.
    assign retime_d = q[STAGES-1];

    always_ff @(negedge in) begin
        if (!rst_q) begin
            retime_q <= 1'b0;
        end else begin
            retime_q <= retime_d;
        end
    end

    assign out_async   = q[STAGES-1];
    assign out_retimed = retime_q;

endmodule : fdiv16_async_retime_core

// File: tb/tb_fdiv16_async_retime_core.sv
// Scoreboard bench for the ripple divider: a cycle model predicts both outputs
// for the default divide-by-16 core and a divide-by-4 instance sharing the reset.
`timescale 1ps/1ps
module tb_fdiv16_async_retime_core;

    localparam real HALF_PS = 1.0e12 / (2.0 * fdiv_pkg::F_IN_NOM);

    typedef struct {
        logic v;
        logic a16;
        logic r16;
        logic a4;
        logic r4;
    } exp_t;

    logic clk_in;
    logic rstn;
    logic async16, ret16, async4, ret4;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_rise = 0;
    bit   done   = 0;

    logic       rq_m = 1'b1;
    logic       cv   = 1'b0;
    logic [3:0] c16  = 4'd0;
    logic [1:0] c4   = 2'd0;

    fdiv16_async_retime_core u_dut16 (
        .in          (clk_in),
        .rstn        (rstn),
        .out_async   (async16),
        .out_retimed (ret16)
    );

    fdiv16_async_retime_core #(.STAGES(2)) u_dut4 (
        .in          (clk_in),
        .rstn        (rstn),
        .out_async   (async4),
        .out_retimed (ret4)
    );

    initial clk_in = 1'b0;
    always #(HALF_PS) clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive rstn for one cycle, advance the model at the edge and queue the prediction.
    task automatic step(input logic r);
        exp_t e;
        rstn = r;
        @(posedge clk_in);
        if (!rq_m) begin
            c16 = 4'd0;
            c4  = 2'd0;
            cv  = 1'b1;
        end else if (!r) begin
            cv = 1'b0;
        end else begin
            c16 = c16 + 4'd1;
            c4  = c4 + 2'd1;
        end
        rq_m  = r;
        e.v   = cv;
        e.a16 = c16[3];
        e.a4  = c4[1];
        e.r16 = rq_m ? c16[3] : 1'b0;
        e.r4  = rq_m ? c4[1] : 1'b0;
        sb.push_back(e);
        #20;
    endtask

    always @(posedge async16) n_rise++;

    // Retimed edges must land on a falling edge of the input clock.
    always @(ret16) begin
        if ($time > 0) check("ret16_on_fall", 32'(clk_in), 32'd0);
    end

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk_in);
            #100;
            if (sb.size() == 0) begin
                if (!done) check("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                if (e.v) begin
                    check("async16", 32'(async16), 32'(e.a16));
                    check("async4", 32'(async4), 32'(e.a4));
                end
                @(negedge clk_in);
                #100;
                check("retimed16", 32'(ret16), 32'(e.r16));
                check("retimed4", 32'(ret4), 32'(e.r4));
            end
        end
    end

    initial begin : driver
        int rise0;
        rstn = 1'b0;
        repeat (4) step(1'b0);

        // E0, then 200 full output periods of free running.
        step(1'b1);
        rise0 = n_rise;
        repeat (3200) step(1'b1);
        check("rises_200", 32'(n_rise - rise0), 32'd200);

        // Reset asserted while the count is 11 (output high).
        for (int i = 0; i < 40 && !(cv && c16 == 4'd11); i++) step(1'b1);
        check("reach11", 32'(c16), 32'd11);
        step(1'b0);
        step(1'b0);
        check("cnt_cleared", 32'(c16), 32'd0);
        repeat (40) step(1'b1);

        // Single-cycle reset pulses at assorted counts.
        repeat (6) begin
            repeat ($urandom_range(1, 20)) step(1'b1);
            step(1'b0);
        end
        repeat (40) step(1'b1);

        done = 1'b1;
        #2000;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fdiv16_async_retime_core
